// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the multi-master SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, WRITE_REC} arb_state_e;

  localparam int ARB_SEL  = 0;
  localparam int ARB_PRIO = 1;
  localparam int ARB_RR   = 2;

  function automatic int log2ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sram_arb_multi_rr_pick.sv
// Rotating picker: first requester strictly after `last`, wrapping around.
module rr_pick import sram_arb_pkg::*; #(
  parameter  int N  = 4,
  localparam int IW = log2ceil(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          valid
);

  function automatic logic [IW-1:0] cand(input logic [IW-1:0] l, input int k);
    return IW'((int'(l) + k) % N);
  endfunction

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[cand(last, k)]) begin
        idx   = cand(last, k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arb_multi.sv
// N-master arbiter for the asynchronous 16-bit SRAM: select / priority / round-robin,
// one fixed-length read or write cycle per accept, all pins driven from registers.
module sram_arb_multi import sram_arb_pkg::*; #(
  parameter  int ADDR_WIDTH  = 20,
  parameter  int DATA_WIDTH  = 16,
  parameter  int NUM_MASTERS = 4,
  parameter  int SEL_WIDTH   = 2,
  parameter  int MODE        = ARB_RR,
  localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [SEL_WIDTH-1:0]              sel,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_byteenable,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata,
  output logic [NUM_MASTERS-1:0]            m_waitrequest,
  output logic [DATA_WIDTH-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]            m_readdataready,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic [ADDR_WIDTH-1:0]             sram_address,
  inout  wire  [DATA_WIDTH-1:0]             sram_data,
  output logic                              sram_ce_n,
  output logic                              sram_oe_n,
  output logic                              sram_we_n,
  output logic [BE_WIDTH-1:0]               sram_be_n
);

  localparam int IW = log2ceil(NUM_MASTERS);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr;
  } req_t;

  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [NUM_MASTERS-1:0][BE_WIDTH-1:0]   be_a;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] wd_a;

  assign addr_a = m_address;
  assign be_a   = m_byteenable;
  assign wd_a   = m_writedata;

  arb_state_e            state;
  logic [IW-1:0]         last_grant;
  logic                  data_oe;
  logic [DATA_WIDTH-1:0] dout;

  logic [NUM_MASTERS-1:0] req_v;
  logic [IW-1:0]          rr_last, rr_idx, win;
  logic                   rr_vld, win_vld, accept;
  req_t                   acc_req;

  assign req_v = m_read | m_write;

  // Fixed priority is round-robin anchored just before master 0.
  assign rr_last = (MODE == ARB_PRIO) ? IW'(NUM_MASTERS - 1) : last_grant;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req   (req_v),
    .last  (rr_last),
    .idx   (rr_idx),
    .valid (rr_vld)
  );

  always_comb begin
    win     = rr_idx;
    win_vld = rr_vld;
    if (MODE == ARB_SEL) begin
      win     = IW'(sel);
      win_vld = (int'(sel) < NUM_MASTERS) && req_v[win];
    end
  end

  assign accept = !reset && (state == IDLE) && win_vld;

  always_comb begin
    m_waitrequest = '1;
    if (accept) m_waitrequest[win] = 1'b0;
  end

  always_comb begin
    acc_req.addr  = addr_a[win];
    acc_req.be    = be_a[win];
    acc_req.wdata = wd_a[win];
    acc_req.wr    = m_write[win];
  end

  // Strobes are set for the state being entered, so every pin is a flop output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      grant           <= '0;
      last_grant      <= IW'(NUM_MASTERS - 1);
      sram_address    <= '0;
      sram_ce_n       <= 1'b1;
      sram_oe_n       <= 1'b1;
      sram_we_n       <= 1'b1;
      sram_be_n       <= '1;
      m_readdata      <= '0;
      m_readdataready <= '0;
      data_oe         <= 1'b0;
      dout            <= '0;
    end else begin
      m_readdataready <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            grant        <= NUM_MASTERS'(1) << win;
            last_grant   <= win;
            sram_address <= acc_req.addr;
            sram_be_n    <= ~acc_req.be;
            sram_ce_n    <= 1'b0;
            if (acc_req.wr) begin
              state     <= WRITE;
              sram_we_n <= 1'b0;
              data_oe   <= 1'b1;
              dout      <= acc_req.wdata;
            end else begin
              state     <= READ;
              sram_oe_n <= 1'b0;
            end
          end
        end
        READ: begin
          m_readdata      <= sram_data;
          m_readdataready <= grant;
          grant           <= '0;
          sram_ce_n       <= 1'b1;
          sram_oe_n       <= 1'b1;
          sram_be_n       <= '1;
          state           <= IDLE;
        end
        WRITE: begin
          sram_we_n <= 1'b1;
          state     <= WRITE_REC;
        end
        WRITE_REC: begin
          sram_ce_n <= 1'b1;
          sram_be_n <= '1;
          data_oe   <= 1'b0;
          grant     <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sram_data = data_oe ? dout : 'z;

endmodule

// File: tb/tb_sram_arb_multi.sv
// Three arbiters (select, priority, round-robin) share one stimulus; each is checked
// every cycle against a transaction-level model, plus directed literal scenarios.
module tb_sram_arb_multi;
  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0]      sel;
  logic [N*AW-1:0] m_address;
  logic [N*BW-1:0] m_byteenable;
  logic [N-1:0]    m_read, m_write;
  logic [N*DW-1:0] m_writedata;

  logic [N-1:0]  wrq[3], gnt[3], rdy[3];
  logic [DW-1:0] rdata[3], sdo[3];
  logic [AW-1:0] saddr[3];
  logic          ce_n[3], oe_n[3], we_n[3];
  logic [BW-1:0] be_n[3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    wire  [DW-1:0] sd;
    logic [DW-1:0] mem [256];
    logic          drv;

    initial for (int i = 0; i < 256; i++) mem[i] = {8'hBE, 8'(i)};

    assign drv    = !ce_n[k] && !oe_n[k] && we_n[k];
    assign sd     = drv ? mem[saddr[k][7:0]] : 'z;
    assign sdo[k] = sd;

    always @(negedge clock)
      if (!ce_n[k] && !we_n[k])
        for (int b = 0; b < BW; b++)
          if (!be_n[k][b]) mem[saddr[k][7:0]][b*8 +: 8] <= sd[b*8 +: 8];

    sram_arb_multi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(N),
                     .SEL_WIDTH(2), .MODE(k)) u_dut (
      .clock           (clock),
      .reset           (reset),
      .sel             (sel),
      .m_address       (m_address),
      .m_byteenable    (m_byteenable),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_waitrequest   (wrq[k]),
      .m_readdata      (rdata[k]),
      .m_readdataready (rdy[k]),
      .grant           (gnt[k]),
      .sram_address    (saddr[k]),
      .sram_data       (sd),
      .sram_ce_n       (ce_n[k]),
      .sram_oe_n       (oe_n[k]),
      .sram_we_n       (we_n[k]),
      .sram_be_n       (be_n[k])
    );
  end

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d act=%0h exp=%0h", nm, m, cyc, act, exp);
    end
  endtask

  // ---------------- reference model: expected pin picture per cycle ----------------
  typedef struct packed {
    logic          ce_n, oe_n, we_n;
    logic [BW-1:0] be_n;
    logic [AW-1:0] addr;
    logic          drv;
    logic [DW-1:0] wd;
    logic [N-1:0]  grant;
    logic [N-1:0]  rdy;
    logic [DW-1:0] rd;
  } pins_t;

  pins_t         sch[3][3];
  int            busy[3];
  int            last_g[3];
  logic [AW-1:0] last_a[3];
  logic [DW-1:0] mdl_mem[3][256];
  int            acc_g[3][$];
  int            acc_t[3][$];

  initial
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 256; i++) mdl_mem[m][i] = {8'hBE, 8'(i)};

  function automatic pins_t idle_p(input logic [AW-1:0] a);
    pins_t p;
    p      = '0;
    p.ce_n = 1'b1;
    p.oe_n = 1'b1;
    p.we_n = 1'b1;
    p.be_n = '1;
    p.addr = a;
    return p;
  endfunction

  function automatic int pick(input int mode, input logic [N-1:0] req, input int sl, input int lg);
    int r;
    r = -1;
    if (mode == 0) begin
      if (req[sl]) r = sl;
    end else if (mode == 1) begin
      for (int i = 0; i < N && r < 0; i++) if (req[i]) r = i;
    end else begin
      for (int k = 1; k <= N && r < 0; k++) if (req[(lg + k) % N]) r = (lg + k) % N;
    end
    return r;
  endfunction

  task automatic mdl_step(input int m);
    pins_t         e, p;
    logic [N-1:0]  ewr;
    int            g;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    if (reset) begin
      for (int k = 0; k < 3; k++) sch[m][k] = idle_p('0);
      busy[m]   = 0;
      last_g[m] = N - 1;
      last_a[m] = '0;
    end
    e = sch[m][0];
    chk("ce_n", m, 32'(ce_n[m]), 32'(e.ce_n));
    chk("oe_n", m, 32'(oe_n[m]), 32'(e.oe_n));
    chk("we_n", m, 32'(we_n[m]), 32'(e.we_n));
    chk("be_n", m, 32'(be_n[m]), 32'(e.be_n));
    chk("addr", m, 32'(saddr[m]), 32'(e.addr));
    chk("grant", m, 32'(gnt[m]), 32'(e.grant));
    chk("rdy", m, 32'(rdy[m]), 32'(e.rdy));
    if (e.rdy != '0) chk("readdata", m, 32'(rdata[m]), 32'(e.rd));
    if (e.drv) chk("sram_data", m, 32'(sdo[m]), 32'(e.wd));
    if (!reset && !e.we_n)
      for (int b = 0; b < BW; b++)
        if (!e.be_n[b]) mdl_mem[m][e.addr[7:0]][b*8 +: 8] = e.wd[b*8 +: 8];

    g   = -1;
    ewr = '1;
    if (!reset && busy[m] == 0) g = pick(m, m_read | m_write, int'(sel), last_g[m]);
    if (g >= 0) ewr[g] = 1'b0;
    chk("waitrequest", m, 32'(wrq[m]), 32'(ewr));

    if (g >= 0) begin
      a  = m_address[g*AW +: AW];
      be = m_byteenable[g*BW +: BW];
      wd = m_writedata[g*DW +: DW];
      last_g[m] = g;
      last_a[m] = a;
      acc_g[m].push_back(g);
      acc_t[m].push_back(cyc);
      p       = idle_p(a);
      p.ce_n  = 1'b0;
      p.be_n  = ~be;
      p.grant = N'(1) << g;
      if (m_write[g]) begin
        p.we_n = 1'b0;
        p.drv  = 1'b1;
        p.wd   = wd;
        sch[m][1] = p;
        p.we_n = 1'b1;
        sch[m][2] = p;
        busy[m] = 2;
      end else begin
        p.oe_n = 1'b0;
        sch[m][1] = p;
        p      = idle_p(a);
        p.rdy  = N'(1) << g;
        p.rd   = mdl_mem[m][a[7:0]];
        sch[m][2] = p;
        busy[m] = 1;
      end
    end else if (busy[m] > 0) begin
      busy[m]--;
    end
    sch[m][0] = sch[m][1];
    sch[m][1] = sch[m][2];
    sch[m][2] = idle_p(last_a[m]);
  endtask

  always @(negedge clock) begin
    cyc++;
    for (int m = 0; m < 3; m++) mdl_step(m);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic clr();
    for (int m = 0; m < 3; m++) begin
      acc_g[m].delete();
      acc_t[m].delete();
    end
  endtask

  initial begin
    sel          = '0;
    m_read       = '1;
    m_write      = '0;
    m_byteenable = '1;
    m_writedata  = '0;
    m_address    = '0;
    for (int i = 0; i < N; i++) m_address[i*AW +: AW] = AW'(20'h00100 + i);
    step(2);

    // reset values, with requests present
    chk("rst_wrq", 2, 32'(wrq[2]), 32'hF);
    chk("rst_grant", 2, 32'(gnt[2]), 32'h0);
    chk("rst_ce_n", 2, 32'(ce_n[2]), 32'h1);
    chk("rst_be_n", 2, 32'(be_n[2]), 32'h3);
    chk("rst_addr", 2, 32'(saddr[2]), 32'h0);
    chk("rst_rdy", 2, 32'(rdy[2]), 32'h0);
    m_read = '0;
    reset  = 1'b0;
    step(1);

    // round-robin with every master reading continuously
    clr();
    m_read = 4'hF;
    step(10);
    m_read = '0;
    step(3);
    chk("rr_count", 2, 32'(acc_g[2].size()), 32'd5);
    if (acc_g[2].size() == 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 2, 32'(acc_g[2][i]), 32'(i % 4));
      for (int i = 0; i < 4; i++) chk("rr_gap", 2, 32'(acc_t[2][i+1] - acc_t[2][i]), 32'd2);
    end

    // fixed priority: master 0 jumps in mid-transfer, master 3 waits for 0 and 1
    clr();
    m_read = 4'b1010;
    step(1);
    m_read = 4'b1011;
    step(2);
    m_read = 4'b1010;
    step(2);
    m_read = 4'b1000;
    step(2);
    m_read = '0;
    step(3);
    chk("prio_count", 1, 32'(acc_g[1].size()), 32'd4);
    if (acc_g[1].size() == 4) begin
      chk("prio_0", 1, 32'(acc_g[1][0]), 32'd1);
      chk("prio_1", 1, 32'(acc_g[1][1]), 32'd0);
      chk("prio_2", 1, 32'(acc_g[1][2]), 32'd1);
      chk("prio_3", 1, 32'(acc_g[1][3]), 32'd3);
    end

    // external select: master 2 writes 0xBEEF, low byte only, then reads it back
    sel = 2'd2;
    m_address[2*AW +: AW]    = 20'h12345;
    m_byteenable[2*BW +: BW] = 2'b01;
    m_writedata[2*DW +: DW]  = 16'hBEEF;
    m_write = 4'b0100;
    step(1);
    chk("wr_we_n", 0, 32'(we_n[0]), 32'h0);
    chk("wr_oe_n", 0, 32'(oe_n[0]), 32'h1);
    chk("wr_be_n", 0, 32'(be_n[0]), 32'h2);
    chk("wr_addr", 0, 32'(saddr[0]), 32'h12345);
    chk("wr_data", 0, 32'(sdo[0]), 32'hBEEF);
    m_write = '0;
    step(1);
    chk("rec_we_n", 0, 32'(we_n[0]), 32'h1);
    chk("rec_ce_n", 0, 32'(ce_n[0]), 32'h0);
    chk("rec_data", 0, 32'(sdo[0]), 32'hBEEF);
    step(1);
    chk("idle_ce_n", 0, 32'(ce_n[0]), 32'h1);
    m_read = 4'b0100;
    step(1);
    chk("rd_oe_n", 0, 32'(oe_n[0]), 32'h0);
    m_read = '0;
    step(1);
    chk("rd_rdy", 0, 32'(rdy[0]), 32'h4);
    chk("rd_data", 0, 32'(rdata[0]), 32'hBEEF);
    step(2);

    // select changes during master 0's write
    clr();
    m_byteenable = '1;
    sel     = 2'd0;
    m_write = 4'b0011;
    step(1);
    sel     = 2'd1;
    m_write = 4'b0010;
    step(3);
    m_write = '0;
    step(3);
    chk("sel_count", 0, 32'(acc_g[0].size()), 32'd2);
    if (acc_g[0].size() == 2) begin
      chk("sel_first", 0, 32'(acc_g[0][0]), 32'd0);
      chk("sel_second", 0, 32'(acc_g[0][1]), 32'd1);
      chk("sel_gap", 0, 32'(acc_t[0][1] - acc_t[0][0]), 32'd3);
    end

    // reset during a read aborts it; round-robin restarts at master 0
    m_read = 4'b0001;
    step(1);
    chk("pre_rst_oe_n", 2, 32'(oe_n[2]), 32'h0);
    reset = 1'b1;
    #1;
    chk("abort_ce_n", 2, 32'(ce_n[2]), 32'h1);
    chk("abort_oe_n", 2, 32'(oe_n[2]), 32'h1);
    chk("abort_grant", 2, 32'(gnt[2]), 32'h0);
    chk("abort_wrq", 2, 32'(wrq[2]), 32'hF);
    m_read = '0;
    step(2);
    reset = 1'b0;
    clr();
    m_read = 4'hF;
    step(1);
    m_read = '0;
    step(3);
    chk("post_rst_count", 2, 32'(acc_g[2].size()), 32'd1);
    if (acc_g[2].size() == 1) chk("post_rst_first", 2, 32'(acc_g[2][0]), 32'd0);

    // read and write together: the write wins
    sel     = 2'd1;
    m_read  = 4'b0010;
    m_write = 4'b0010;
    step(1);
    chk("rw_we_n", 0, 32'(we_n[0]), 32'h0);
    chk("rw_oe_n", 0, 32'(oe_n[0]), 32'h1);
    m_read  = '0;
    m_write = '0;
    step(2);
    chk("rw_rdy", 0, 32'(rdy[0]), 32'h0);
    step(2);

    // randomized traffic, occasional reset
    repeat (3000) begin
      sel     = 2'($urandom);
      m_read  = 4'($urandom) & 4'($urandom);
      m_write = 4'($urandom) & 4'($urandom) & 4'($urandom);
      for (int i = 0; i < N; i++) begin
        m_address[i*AW +: AW]    = {12'($urandom), 4'h0, 4'($urandom)};
        m_byteenable[i*BW +: BW] = 2'($urandom);
        m_writedata[i*DW +: DW]  = 16'($urandom);
      end
      reset = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset   = 1'b0;
    m_read  = '0;
    m_write = '0;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
